// File: rtl/f2s_pkg.sv
// Shared types and constants for the clk1 -> clk2 counter handshake transfer.
package f2s_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } f2s_state_e;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int STATS_W         = 16;

endpackage

// File: rtl/f2s_sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous active-high clear.
module f2s_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) sync_q <= '0;
        else         sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/f2s_count_xfer_ctrl.sv
// Free-running clk1 counter handed to clk2 through a held snapshot and 4-phase req/ack.
// Optional stats outputs xfer_cnt/req_drop are built when F2S_XFER_STATS_EN is defined.
module f2s_count_xfer_ctrl
    import f2s_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             clk2,
    input  logic             count_en,
    input  logic             auto_mode,
    input  logic             xfer_req,
    output logic [WIDTH-1:0] count_1,
    output logic             busy,
    output logic             xfer_done,
    output logic [WIDTH-1:0] count_2,
    output logic             upd
`ifdef F2S_XFER_STATS_EN
    ,
    output logic [STATS_W-1:0] xfer_cnt,
    output logic [STATS_W-1:0] req_drop
`endif
);

    localparam int SYNC_N = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

    f2s_state_e       state_q, state_d;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] snap_q, snap_d;
    logic             req_q, req_d;
    logic             pend_q, pend_d;
    logic             done_q, done_d;
    logic             ack_s;

    logic             req_s;
    logic             ack_q;
    logic [WIDTH-1:0] count2_q;
    logic             upd_q;

    // ---------------- clk1 domain ----------------
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset)         cnt_q <= '0;
        else if (count_en) cnt_q <= cnt_q + 1'b1;
    end

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            snap_q  <= '0;
            req_q   <= 1'b0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            req_q   <= req_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        req_d   = req_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer_req || pend_q || auto_mode) begin
                    snap_d  = cnt_q;
                    req_d   = 1'b1;
                    pend_d  = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (xfer_req) pend_d = 1'b1;
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = REL;
                end
            end
            REL: begin
                if (xfer_req) pend_d = 1'b1;
                if (!ack_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    f2s_sync_bit #(.STAGES(SYNC_N)) u_sync_ack (
        .clk_i   (clk1),
        .reset_i (reset),
        .d_i     (ack_q),
        .q_o     (ack_s)
    );

    // ---------------- clk2 domain ----------------
    f2s_sync_bit #(.STAGES(SYNC_N)) u_sync_req (
        .clk_i   (clk2),
        .reset_i (reset),
        .d_i     (req_q),
        .q_o     (req_s)
    );

    // snap_q is frozen from launch until ack_s drops, so this multi-bit capture is safe.
    always_ff @(posedge clk2 or posedge reset) begin
        if (reset) begin
            ack_q    <= 1'b0;
            count2_q <= '0;
            upd_q    <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            if (req_s && !ack_q) begin
                count2_q <= snap_q;
                ack_q    <= 1'b1;
                upd_q    <= 1'b1;
            end else if (!req_s && ack_q) begin
                ack_q <= 1'b0;
            end
        end
    end

`ifdef F2S_XFER_STATS_EN
    logic [STATS_W-1:0] xfer_cnt_q;
    logic [STATS_W-1:0] req_drop_q;

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            xfer_cnt_q <= '0;
            req_drop_q <= '0;
        end else begin
            if (done_d) xfer_cnt_q <= xfer_cnt_q + 1'b1;
            if (xfer_req && (state_q != IDLE) && pend_q && (req_drop_q != '1))
                req_drop_q <= req_drop_q + 1'b1;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
    assign req_drop = req_drop_q;
`endif

    assign count_1   = cnt_q;
    assign busy      = (state_q != IDLE);
    assign xfer_done = done_q;
    assign count_2   = count2_q;
    assign upd       = upd_q;

endmodule

// File: doc/f2s_count_xfer_ctrl.md
# f2s_count_xfer_ctrl

- Moves a clk1-domain free-running counter value into the slower clk2 domain using a 4-phase req/ack handshake.
- The value crosses as a multi-bit bus with no Gray coding. A snapshot register in clk1 is held stable for the whole handshake, so count_2 never samples a changing bus.
- The clk1 FSM sequences snapshot, request, acknowledge and release; the clk2 side captures and acknowledges.
- Sits between the fast counter datapath and slow-domain consumers, and replaces direct cross-domain sampling of count_1.

## Interface
Parameters:
- WIDTH, 4, counter and transfer width.
- SYNC_STAGES, 2, flops per synchronizer chain (minimum 2).

Ports:
- clk1  input  1  fast clock; FSM, counter and snapshot domain.
- reset  input  1  asynchronous, active-high; clears both domains.
- clk2  input  1  slow clock; capture domain.
- count_en  input  1  clk1; count_1 increments when high.
- auto_mode  input  1  clk1; 1 = relaunch a transfer on every return to IDLE.
- xfer_req  input  1  clk1; single-cycle pulse requesting one transfer.
- count_1  output  WIDTH  clk1 counter.
- busy  output  1  clk1; high in any state other than IDLE.
- xfer_done  output  1  clk1; one-cycle pulse when a handshake completes.
- count_2  output  WIDTH  clk2; last transferred value.
- upd  output  1  clk2; one-cycle pulse in the cycle count_2 changes.

## Operation
Counter:
- count_1 increments by 1 on each clk1 edge with count_en = 1.
- Wraps from 2^WIDTH−1 to 0 with no flag.

clk1 FSM, states IDLE, REQ, REL:
- **IDLE.** Launches a transfer if xfer_req = 1, pend = 1 or auto_mode = 1.
  - On launch: snap <= count_1 (pre-increment value of that edge), req <= 1, clear pend, go to REQ.
- **REQ.** Waits for ack_s = 1, then req <= 0 and go to REL.
- **REL.** Waits for ack_s = 0, then xfer_done = 1 for one cycle and go to IDLE.

Pending requests:
- xfer_req while busy sets pend, one deep; further requests while pend is set are absorbed.
- xfer_req in IDLE launches directly and does not set pend.
- snap is written only on launch and is stable while req or ack_s is high.

clk2 side:
- req_s = req through SYNC_STAGES clk2 flops.
- On the clk2 edge where req_s = 1 and ack = 0: count_2 <= snap, ack <= 1, upd = 1.
- On the clk2 edge where req_s = 0 and ack = 1: ack <= 0.
- ack_s = ack through SYNC_STAGES clk1 flops.

Reset values: count_1, snap, count_2 = 0; req, ack, pend, busy, xfer_done, upd = 0; FSM in IDLE.

Reset mid-handshake:
- Both domains clear asynchronously and all synchronizer flops clear.
- No upd or xfer_done pulse is produced for the aborted transfer.

## Timing
- req rises on the clk1 launch edge.
- count_2 and upd change on the (SYNC_STAGES+1)th clk2 edge after req rises. With SYNC_STAGES = 2 this is the 3rd edge, plus up to one clk2 period of phase uncertainty.
- Round trip launch → xfer_done ≈ 2·(SYNC_STAGES+1) clk2 periods + 2·SYNC_STAGES clk1 periods.
- auto_mode back-to-back: the next launch is on the clk1 edge after xfer_done; the xfer_done cycle is itself IDLE and launches.
- count_en, auto_mode and xfer_req have no effect on an in-flight snap.
- Ratio clk1:clk2 is arbitrary. Correctness does not depend on clk1 being faster.

## Configuration
- `F2S_XFER_STATS_EN` defined:
  - Adds output xfer_cnt [15:0] (clk1), incremented on each xfer_done and wrapping at 0xFFFF.
  - Adds output req_drop [15:0] (clk1), incremented on each xfer_req that arrives while pend is already set, saturating at 0xFFFF.
  - Both reset to 0.
- Undefined: neither port exists and no stats logic is built.

## Structure
- Shared package f2s_pkg holds:
  - the FSM state enum (IDLE, REQ, REL);
  - SYNC_STAGES_MIN = 2;
  - stats counter width = 16.
- One sub-module, f2s_sync_bit: a 1-bit SYNC_STAGES-deep synchronizer with async reset, instantiated twice (req → clk2, ack → clk1).

## Test plan
- **Ratio:** clk1 = 100 MHz, clk2 = 25 MHz in all scenarios.
- **Reset:** reset high then release, no requests → all outputs 0, busy = 0, count_2 = 0.
- **Single transfer:** count_en = 1, xfer_req pulsed when count_1 = 5 → snap = 5; count_2 = 5 with one upd pulse; later xfer_done pulse; busy falls.
- **Wrap:** count_en = 1, auto_mode = 1 for 40 clk1 cycles from 0 → count_1 wraps 15→0. Every count_2 change equals some earlier count_1 value, and successive values are mod-16 non-decreasing along clk1 time.
- **Pending:** three xfer_req pulses while busy → exactly one extra transfer after the current one. With `F2S_XFER_STATS_EN` defined: req_drop = 2, xfer_cnt = 2.
- **Reset mid-handshake:** assert reset while in REQ after req_s = 1 → count_2 = 0, no upd or xfer_done pulse. A later xfer_req completes normally.
- **Stability:** assertion that snap never changes while req | ack_s = 1, held across a randomized phase sweep of clk2.
